// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the next-PC logic:
//   pc_sel_e          - next-PC source, one value per redirect class
//   RESET_VECTOR_DEF  - default reset PC
//   EXC_VECTOR_DEF    - default exception redirect target
//   branch_target()   - pc_plus4 + (sign-extended word offset << 2), 64-bit
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_BR,
        PC_J,
        PC_JR,
        PC_EXC
    } pc_sel_e;

    localparam logic [63:0] RESET_VECTOR_DEF = 64'h0000_0000_0000_0000;
    localparam logic [63:0] EXC_VECTOR_DEF   = 64'h0000_0000_0000_0080;

    // Computed at the widest legal address width; callers truncate to ADDR_W,
    // which keeps the result correct modulo 2^ADDR_W.
    function automatic logic [63:0] branch_target(input logic [63:0] pc_plus4,
                                                  input logic [15:0] imm16);
        return pc_plus4 + {{46{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Circular return-address stack. A push when full overwrites the oldest entry;
// a pop when empty leaves the pointer alone and pulses underflow.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push            write push_data as the new top entry
//   pop             discard the top entry
//   push_data       return address to push
//   top             current top entry (0 when empty)
//   count           number of valid entries (saturates at RAS_DEPTH)
//   underflow       one-cycle pulse after a pop on an empty stack
// -----------------------------------------------------------------------------
module ras_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         underflow
);

    localparam int PW = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] entries [RAS_DEPTH];
    logic [PW-1:0]     wr_ptr;   // slot the next push writes; top is wr_ptr-1
    logic [PW-1:0]     top_idx;

    assign top_idx = wr_ptr - PW'(1);
    assign top     = (count == '0) ? '0 : entries[top_idx];

    // NOTE: the entry array has no reset; count gates every read, so stale
    // contents are never visible and the storage can map to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push && !pop) begin
            entries[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (pop) begin
                if (count == '0) begin
                    underflow <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr - PW'(1);
                    count  <= count - 1'b1;
                end
            end else if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (count != (PW+1)'(RAS_DEPTH)) begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Registered program counter with next-PC selection (exc > jr > j/jal >
// taken branch > sequential), a pending-redirect latch for redirects that
// arrive during a stall, and a return-address stack for JAL/JR returns.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   stall           hold PC this cycle (redirects are latched as pending)
//   exc             exception redirect to EXC_VECTOR
//   branch          BEQ decoded;  branch_ne  BNE decoded;  zero  ALU zero flag
//   imm16           signed word offset for branches
//   jump, jal       J / JAL decoded (jal pushes pc_plus4);  jidx  jump index
//   jr, jr_ret      JR decoded / JR is a return (pops RAS)
//   jr_target       register value for JR
//   pc, pc_plus4    current PC and PC+4
//   ras_top, ras_count, ras_underflow   return-address stack status
//   misalign        one-cycle pulse after a JR to a non-word-aligned target
// -----------------------------------------------------------------------------
module pc_unit
    import mips_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter logic [63:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [63:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         exc,
    input  logic                         branch,
    input  logic                         branch_ne,
    input  logic                         zero,
    input  logic [15:0]                  imm16,
    input  logic                         jump,
    input  logic                         jal,
    input  logic [25:0]                  jidx,
    input  logic                         jr,
    input  logic                         jr_ret,
    input  logic [ADDR_W-1:0]            jr_target,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_plus4,
    output logic [ADDR_W-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_underflow,
    output logic                         misalign
);

    localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_VECTOR);
    localparam logic [ADDR_W-1:0] EXC_PC    = ADDR_W'(EXC_VECTOR);
    localparam logic [ADDR_W-1:0] LOW28_MSK = ADDR_W'(28'hFFF_FFFF);

    pc_sel_e           sel;
    logic              taken;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] jr_tgt;
    logic [ADDR_W-1:0] live_tgt;
    logic [ADDR_W-1:0] pend_tgt;
    logic              pend_valid;
    logic              ras_push;
    logic              ras_pop;

    assign pc_plus4 = pc + ADDR_W'(4);
    assign br_tgt   = ADDR_W'(branch_target(64'(pc_plus4), imm16));
    // Upper bits above the 28-bit jump region come from pc_plus4; written as a
    // mask so the expression stays legal at ADDR_W == 28.
    assign j_tgt    = (pc_plus4 & ~LOW28_MSK) | ADDR_W'({jidx, 2'b00});
    assign jr_tgt   = {jr_target[ADDR_W-1:2], 2'b00};
    assign taken    = (branch && zero) || (branch_ne && !zero);

    // NOTE: every signal written in this block is given a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel      = PC_SEQ;
        live_tgt = pc_plus4;
        if (exc) begin
            sel      = PC_EXC;
            live_tgt = EXC_PC;
        end else if (jr) begin
            sel      = PC_JR;
            live_tgt = jr_tgt;
        end else if (jump || jal) begin
            sel      = PC_J;
            live_tgt = j_tgt;
        end else if (taken) begin
            sel      = PC_BR;
            live_tgt = br_tgt;
        end
    end

    // RAS side effects only for the winning redirect of an unstalled cycle.
    assign ras_push = !stall && (sel == PC_J)  && jal;
    assign ras_pop  = !stall && (sel == PC_JR) && jr_ret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RST_PC;
            pend_tgt   <= '0;
            pend_valid <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            misalign <= !stall && (sel == PC_JR) && (jr_target[1:0] != 2'b00);
            if (stall) begin
                // Latest redirect seen during the stall replaces any earlier one.
                if (sel != PC_SEQ) begin
                    pend_tgt   <= live_tgt;
                    pend_valid <= 1'b1;
                end
            end else begin
                pend_valid <= 1'b0;
                if (sel != PC_SEQ) begin
                    pc <= live_tgt;
                end else if (pend_valid) begin
                    pc <= pend_tgt;
                end else begin
                    pc <= pc_plus4;
                end
            end
        end
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .count     (ras_count),
        .underflow (ras_underflow)
    );

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Directed bench for pc_unit at default parameters (ADDR_W=32, RAS_DEPTH=4,
// RESET_VECTOR=0, EXC_VECTOR=0x80). Inputs change 1 ns after a rising edge;
// outputs are checked at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, exc, branch, branch_ne, zero, jump, jal, jr, jr_ret;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic [31:0] jr_target;
    logic [31:0] pc, pc_plus4, ras_top;
    logic [2:0]  ras_count;
    logic        ras_underflow, misalign;

    int errors = 0;
    int checks = 0;

    pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .exc           (exc),
        .branch        (branch),
        .branch_ne     (branch_ne),
        .zero          (zero),
        .imm16         (imm16),
        .jump          (jump),
        .jal           (jal),
        .jidx          (jidx),
        .jr            (jr),
        .jr_ret        (jr_ret),
        .jr_target     (jr_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .ras_top       (ras_top),
        .ras_count     (ras_count),
        .ras_underflow (ras_underflow),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        exc = 0; branch = 0; branch_ne = 0; zero = 0; imm16 = '0;
        jump = 0; jal = 0; jidx = '0; jr = 0; jr_ret = 0; jr_target = '0;
    endtask

    // Plain JR (not a return) to place the PC at a known address.
    task automatic go_to(input logic [31:0] addr);
        jr = 1; jr_target = addr;
        tick();
        clear_strobes();
        check("goto_pc", 64'(pc), 64'(addr));
    endtask

    initial begin
        logic [31:0] jal_pcs [5];
        logic [31:0] pop_exp [4];
        jal_pcs = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h40};
        pop_exp = '{32'h44, 32'h34, 32'h24, 32'h14};

        // ---- reset and free-running ----
        rst = 1; stall = 0; clear_strobes();
        tick(); tick();
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_ras_count", 64'(ras_count), 64'd0);
        check("rst_ras_top", 64'(ras_top), 64'h0);
        check("rst_underflow", 64'(ras_underflow), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        rst = 0;
        check("run_pc0", 64'(pc), 64'h0);
        tick(); check("run_pc1", 64'(pc), 64'h4);
        tick(); check("run_pc2", 64'(pc), 64'h8);
        tick(); check("run_pc3", 64'(pc), 64'hC);
        #2 rst = 1;
        #1 check("async_rst_pc", 64'(pc), 64'h0);
        rst = 0;
        tick();
        check("after_rst_pc", 64'(pc), 64'h4);

        // ---- branches ----
        go_to(32'h100);
        branch = 1; zero = 1; imm16 = 16'hFFFE;
        tick(); clear_strobes();
        check("beq_taken", 64'(pc), 64'hFC);
        go_to(32'h100);
        branch = 1; zero = 0; imm16 = 16'hFFFE;
        tick(); clear_strobes();
        check("beq_not_taken", 64'(pc), 64'h104);
        go_to(32'h100);
        branch_ne = 1; zero = 0; imm16 = 16'h0003;
        tick(); clear_strobes();
        check("bne_taken", 64'(pc), 64'h110);

        // ---- JAL / JR return with misaligned target ----
        go_to(32'h1000_0040);
        jump = 1; jal = 1; jidx = 26'h0000100;
        tick(); clear_strobes();
        check("jal_pc", 64'(pc), 64'h1000_0400);
        check("jal_ras_top", 64'(ras_top), 64'h1000_0044);
        check("jal_ras_count", 64'(ras_count), 64'd1);
        jr = 1; jr_ret = 1; jr_target = 32'h1000_0046;
        tick(); clear_strobes();
        check("jr_ret_pc", 64'(pc), 64'h1000_0044);
        check("jr_misalign", 64'(misalign), 64'd1);
        check("jr_ret_count", 64'(ras_count), 64'd0);
        tick();
        check("misalign_pulse_end", 64'(misalign), 64'd0);

        // ---- stall with pending jump ----
        go_to(32'h8);
        stall = 1; jump = 1; jidx = 26'h20;
        tick(); clear_strobes();
        check("stall_hold0", 64'(pc), 64'h8);
        tick(); check("stall_hold1", 64'(pc), 64'h8);
        tick(); check("stall_hold2", 64'(pc), 64'h8);
        stall = 0;
        tick(); check("pending_load", 64'(pc), 64'h80);
        tick(); check("pending_cleared", 64'(pc), 64'h84);

        // ---- stall, then exception on release beats pending ----
        go_to(32'h8);
        stall = 1; jump = 1; jidx = 26'h40;
        tick(); clear_strobes();
        check("stall2_hold", 64'(pc), 64'h8);
        stall = 0; exc = 1;
        tick(); clear_strobes();
        check("release_exc", 64'(pc), 64'h80);
        tick(); check("release_exc_clear", 64'(pc), 64'h84);

        // ---- RAS overflow and underflow ----
        for (int i = 0; i < 5; i++) begin
            go_to(jal_pcs[i]);
            jump = 1; jal = 1; jidx = 26'h40;
            tick(); clear_strobes();
            check("push_pc", 64'(pc), 64'h100);
            check("push_count", 64'(ras_count), (i < 4) ? 64'(i + 1) : 64'd4);
            check("push_top", 64'(ras_top), 64'(jal_pcs[i] + 32'h4));
        end
        for (int i = 0; i < 4; i++) begin
            check("pop_top", 64'(ras_top), 64'(pop_exp[i]));
            jr = 1; jr_ret = 1; jr_target = 32'h200;
            tick(); clear_strobes();
            check("pop_pc", 64'(pc), 64'h200);
            check("pop_count", 64'(ras_count), 64'(3 - i));
            check("pop_no_underflow", 64'(ras_underflow), 64'd0);
        end
        jr = 1; jr_ret = 1; jr_target = 32'h300;
        tick(); clear_strobes();
        check("underflow_pulse", 64'(ras_underflow), 64'd1);
        check("underflow_count", 64'(ras_count), 64'd0);
        check("underflow_top", 64'(ras_top), 64'h0);
        check("underflow_pc", 64'(pc), 64'h300);
        tick();
        check("underflow_pulse_end", 64'(ras_underflow), 64'd0);

        // ---- exc and jal together: exc wins, no push ----
        go_to(32'h40);
        jump = 1; jal = 1; jidx = 26'h40;
        tick(); clear_strobes();
        check("pre_exc_count", 64'(ras_count), 64'd1);
        exc = 1; jump = 1; jal = 1; jidx = 26'h80;
        tick(); clear_strobes();
        check("exc_jal_pc", 64'(pc), 64'h80);
        check("exc_jal_count", 64'(ras_count), 64'd1);
        check("exc_jal_top", 64'(ras_top), 64'h44);

        // ---- jr and jal together: jr wins, no push ----
        jr = 1; jal = 1; jump = 1; jidx = 26'h80; jr_target = 32'h500;
        tick(); clear_strobes();
        check("jr_jal_pc", 64'(pc), 64'h500);
        check("jr_jal_count", 64'(ras_count), 64'd1);

        // ---- reset while a redirect is pending ----
        stall = 1; jump = 1; jidx = 26'h100;
        tick(); clear_strobes();
        #2 rst = 1;
        #1 check("rst_pend_pc", 64'(pc), 64'h0);
        check("rst_pend_count", 64'(ras_count), 64'd0);
        rst = 0; stall = 0;
        tick();
        check("rst_pend_dropped", 64'(pc), 64'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
